fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the address-only FIFO controller and its storage between NUM_REQ independent producers.
- Grants one producer at a time and holds the grant for a bounded burst.
- Drives the FIFO `wr` strobe and write data, and gates writes with the FIFO `full` flag.
- Sits between the producer blocks and the FIFO write port. The read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, width of each data word
- MAX_BURST, 4, maximum accepted writes per grant before forced release (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req  input  NUM_REQ  per-requester write request; held high while data is pending
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; slice i = req_data[i*DATA_WIDTH +: DATA_WIDTH]
- full  input  1  FIFO full flag
- ack  output  NUM_REQ  one-hot pulse; word of requester i accepted this cycle
- wr  output  1  FIFO write strobe
- w_data  output  DATA_WIDTH  data to FIFO storage
- gnt_valid  output  1  a requester currently owns the port
- gnt_id  output  $clog2(NUM_REQ)  index of the current owner

Behaviour:

Registered state:
- gnt_valid, gnt_id (owner), prio_ptr (next requester to search from), burst_cnt (width $clog2(MAX_BURST+1)).

Reset (reset=0, asynchronous):
- gnt_valid=0, gnt_id=0, prio_ptr=0, burst_cnt=0.
- Outputs: wr=0, ack=0, w_data=0.

State machine, encoded by gnt_valid:
- IDLE (gnt_valid=0):
  - wr=0, ack=0.
  - If any req bit is set, search req circularly starting at prio_ptr; the first set bit becomes gnt_id; gnt_valid<=1; burst_cnt<=0.
  - Grant is visible the cycle after req rises (1-cycle arbitration latency).
- OWN (gnt_valid=1):
  - Combinational write: wr = req[gnt_id] & ~full; ack[gnt_id] = wr; all other ack bits 0.
  - w_data = slice gnt_id while gnt_valid=1, else 0.
  - Each cycle with wr=1: burst_cnt<=burst_cnt+1.
  - Release condition: req[gnt_id]=0, OR (wr=1 AND burst_cnt==MAX_BURST-1).
  - On release: prio_ptr<=(gnt_id+1) mod NUM_REQ. In the same cycle, re-arbitrate from that new pointer over req with the releasing requester masked out.
    - If a winner exists: gnt_id<=winner, burst_cnt<=0, remain in OWN. Hand-over has no dead cycle.
    - Else: gnt_valid<=0 (IDLE).
  - If the releasing requester is the only one still requesting, it is re-granted only after one IDLE cycle.

Boundary conditions:
- full=1 while owning: wr=0, ack=0, burst_cnt holds, grant holds (stall). A stall never counts toward the burst and never forces release.
- Owner drops req with full=1: release immediately, no write.
- Release cycle coincides with a write (last burst word): that word is written and acked; the new owner is registered on the same edge.
- Non-owner req bits have no effect on wr/ack.
- Requester obligations: hold req high and its data slice stable until ack. A requester may drop req at any time; an unacked word is then discarded (not written).
- prio_ptr wraps NUM_REQ-1 -> 0.
- Reset mid-burst: the grant is abandoned immediately; any pending word is not written.
- All ack and wr outputs are combinational from registered state plus req/full. There is no combinational path from req_data to any control output.

Test Plan:
1. Reset, then req=4'b0100 held, full=0 -> gnt_id=2 one cycle later. Then 4 consecutive wr/ack[2] pulses with w_data=slice 2. Release after the 4th write; one IDLE cycle; re-grant to 2.
2. req=4'b1111 held, full=0 -> owners 0,1,2,3,0 in sequence, each for exactly 4 writes. No gap cycles between bursts; prio_ptr wraps 3->0.
3. Owner 1 mid-burst (2 writes done), full=1 for 5 cycles -> wr=0, ack=0, gnt_id stays 1, burst_cnt stays 2. After full=0: exactly 2 more writes, then release.
4. Owner 0 drops req after 1 write while req[3]=1 -> same cycle releases, gnt_id=3 next cycle, no write from 0 in the drop cycle.
5. Assert reset=0 during owner 2's third write cycle -> wr/ack drop immediately. After reset=1 with req=4'b0110: gnt_id=1 (prio_ptr=0).
6. req=4'b0001, full=1 at grant, req dropped while stalled -> zero writes, return to IDLE, gnt_valid=0 next cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// An owner holds the port for up to MAX_BURST accepted words; FIFO stalls never count toward the burst.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          wr,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BW   = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t              state_r, state_n;
  logic [ID_W-1:0]     gnt_id_r, gnt_id_n;
  logic [ID_W-1:0]     prio_ptr_r, prio_ptr_n;
  logic [BW-1:0]       burst_cnt_r, burst_cnt_n;
  logic [NUM_REQ-1:0]  ack_s;
  logic                wr_s;
  logic [DATA_WIDTH-1:0] w_data_s;
  logic                release_s;
  logic [ID_W-1:0]     next_ptr_s;
  logic [ID_W:0]       pick_s;

  // Circular first-set search starting at ptr; returns {found, index}.
  function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] vec,
                                         input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    int              j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && vec[ID_W'(j)]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
    return {found, idx};
  endfunction

  // Grant, priority pointer and burst counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      gnt_id_r    <= '0;
      prio_ptr_r  <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_n;
      gnt_id_r    <= gnt_id_n;
      prio_ptr_r  <= prio_ptr_n;
      burst_cnt_r <= burst_cnt_n;
    end
  end

  // Arbitration, write gating and release / hand-over decisions.
  always_comb begin
    state_n     = state_r;
    gnt_id_n    = gnt_id_r;
    prio_ptr_n  = prio_ptr_r;
    burst_cnt_n = burst_cnt_r;
    ack_s       = '0;
    wr_s        = 1'b0;
    w_data_s    = '0;
    release_s   = 1'b0;
    next_ptr_s  = (gnt_id_r == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_r + ID_W'(1);
    pick_s      = '0;
    case (state_r)
      IDLE: begin
        pick_s = pick(req, prio_ptr_r);
        if (pick_s[ID_W]) begin
          state_n     = OWN;
          gnt_id_n    = pick_s[ID_W-1:0];
          burst_cnt_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      OWN: begin
        w_data_s        = req_data[int'(gnt_id_r)*DATA_WIDTH +: DATA_WIDTH];
        wr_s            = req[gnt_id_r] & ~full;
        ack_s[gnt_id_r] = wr_s;
        if (wr_s) begin
          burst_cnt_n = burst_cnt_r + BW'(1);
        end else begin
          burst_cnt_n = burst_cnt_r;
        end
        release_s = ~req[gnt_id_r] | (wr_s & (burst_cnt_r == BW'(MAX_BURST - 1)));
        if (release_s) begin
          // The releasing owner is masked so a lone requester sees one idle cycle.
          prio_ptr_n = next_ptr_s;
          pick_s     = pick(req & ~(NUM_REQ'(1) << gnt_id_r), next_ptr_s);
          burst_cnt_n = '0;
          if (pick_s[ID_W]) begin
            gnt_id_n = pick_s[ID_W-1:0];
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = OWN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign ack       = ack_s;
  assign wr        = wr_s;
  assign w_data    = w_data_s;
  assign gnt_valid = (state_r == OWN);
  assign gnt_id    = gnt_id_r;

endmodule
